// File: rtl/mil_transmitter.sv
// Manchester word transmitter with a small word FIFO and bus-grant handshake.
// Define MIL_TX_GAP_EN to insert an 8 half-bit quiet gap after every word.
module mil_transmitter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        ioStrobe,
  input  logic        push_request,
  input  logic [1:0]  push_type,
  input  logic [15:0] push_data,
  output logic        push_ready,
  output logic        push_done,
  input  logic        tx_grant,
  output logic        tx_request,
  output logic        tx_busy,
  output logic        mil_TXout,
  output logic        mil_nTXout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [1:0] WSERV = 2'b01;
  localparam logic [1:0] WDATA = 2'b10;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SYNC   = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] GAP    = 3'd4;

  logic [17:0] fifo_mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [17:0] head_s;
  logic        empty_s;
  logic        full_s;
  logic        accept_s;
  logic        valid_type_s;
  logic        launch_ok_s;
  logic        start_s;

  logic [2:0]  state_r;
  logic [3:0]  cnt_r;
  logic        half_r;
  logic [15:0] shift_r;
  logic        par_r;
  logic        wserv_r;
  logic        busy_r;
  logic        tx_r;
  logic        ntx_r;
  logic        push_done_r;

  assign empty_s      = (wr_ptr_r == rd_ptr_r);
  assign full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head_s       = fifo_mem_r[rd_ptr_r[AW-1:0]];
  assign valid_type_s = (push_type == WSERV) || (push_type == WDATA);
  // A full FIFO may still take a word in the cycle the head is popped.
  assign push_ready   = !full_s || start_s;
  assign accept_s     = push_request && push_ready;

  assign push_done  = push_done_r;
  assign tx_busy    = busy_r;
  assign mil_TXout  = tx_r;
  assign mil_nTXout = ntx_r;
  assign tx_request = !empty_s || busy_r;

  // Decide whether a new word may be launched on this strobe.
  always_comb begin
    launch_ok_s = 1'b0;
`ifdef MIL_TX_GAP_EN
    if ((state_r == IDLE) || ((state_r == GAP) && (cnt_r == 4'd7))) begin
      launch_ok_s = 1'b1;
    end else begin
      launch_ok_s = 1'b0;
    end
`else
    if ((state_r == IDLE) || ((state_r == PARITY) && half_r)) begin
      launch_ok_s = 1'b1;
    end else begin
      launch_ok_s = 1'b0;
    end
`endif
    start_s = ioStrobe && tx_grant && !empty_s && launch_ok_s;
  end

  // FIFO storage; invalid word types are acknowledged but never stored.
  always_ff @(posedge clk) begin
    if (accept_s && valid_type_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= {push_type, push_data};
    end
  end

  // FIFO pointers and push acknowledge.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      push_done_r <= 1'b0;
    end else begin
      push_done_r <= accept_s;
      if (accept_s && valid_type_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (start_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Word sequencer: each strobe advances one half-bit and registers the line level.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      half_r  <= 1'b0;
      shift_r <= 16'd0;
      par_r   <= 1'b0;
      wserv_r <= 1'b0;
      busy_r  <= 1'b0;
      tx_r    <= 1'b0;
      ntx_r   <= 1'b0;
    end else if (start_s) begin
      state_r <= SYNC;
      cnt_r   <= 4'd0;
      half_r  <= 1'b0;
      shift_r <= head_s[15:0];
      par_r   <= ~^head_s[15:0];
      wserv_r <= (head_s[17:16] == WSERV);
      busy_r  <= 1'b1;
      tx_r    <= (head_s[17:16] == WSERV);
      ntx_r   <= (head_s[17:16] != WSERV);
    end else if (ioStrobe) begin
      case (state_r)
        IDLE: begin
          busy_r <= 1'b0;
          tx_r   <= 1'b0;
          ntx_r  <= 1'b0;
        end
        SYNC: begin
          if (cnt_r == 4'd5) begin
            state_r <= DATA;
            cnt_r   <= 4'd0;
            half_r  <= 1'b0;
            tx_r    <= shift_r[15];
            ntx_r   <= !shift_r[15];
          end else begin
            cnt_r <= cnt_r + 4'd1;
            tx_r  <= (cnt_r < 4'd2) ? wserv_r : !wserv_r;
            ntx_r <= (cnt_r < 4'd2) ? !wserv_r : wserv_r;
          end
        end
        DATA: begin
          if (!half_r) begin
            half_r <= 1'b1;
            tx_r   <= !shift_r[15];
            ntx_r  <= shift_r[15];
          end else if (cnt_r == 4'd15) begin
            state_r <= PARITY;
            cnt_r   <= 4'd0;
            half_r  <= 1'b0;
            tx_r    <= par_r;
            ntx_r   <= !par_r;
          end else begin
            cnt_r   <= cnt_r + 4'd1;
            half_r  <= 1'b0;
            shift_r <= {shift_r[14:0], 1'b0};
            tx_r    <= shift_r[14];
            ntx_r   <= !shift_r[14];
          end
        end
        PARITY: begin
          if (!half_r) begin
            half_r <= 1'b1;
            tx_r   <= !par_r;
            ntx_r  <= par_r;
          end else begin
`ifdef MIL_TX_GAP_EN
            state_r <= GAP;
`else
            state_r <= IDLE;
`endif
            cnt_r  <= 4'd0;
            half_r <= 1'b0;
            busy_r <= 1'b0;
            tx_r   <= 1'b0;
            ntx_r  <= 1'b0;
          end
        end
        GAP: begin
          if (cnt_r == 4'd7) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
          busy_r <= 1'b0;
          tx_r   <= 1'b0;
          ntx_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          half_r  <= 1'b0;
          busy_r  <= 1'b0;
          tx_r    <= 1'b0;
          ntx_r   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mil_transmitter.sv
// Self-checking bench for mil_transmitter: table-driven push vectors, fixed corner
// sequences and random batches checked against a half-bit reference model.
module tb_mil_transmitter;
  localparam int DEPTH = 4;
`ifdef MIL_TX_GAP_EN
  localparam int GAP_HB = 8;
`else
  localparam int GAP_HB = 0;
`endif
  localparam logic [39:0] LIT_S = 40'b111000_01010101_01011001_10011001_01010110_10;
  localparam logic [39:0] LIT_D = 40'b000111_01010101_01011001_10011001_01010110_10;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        ioStrobe = 1'b0;
  logic        push_request = 1'b0;
  logic [1:0]  push_type = 2'b00;
  logic [15:0] push_data = 16'h0000;
  logic        tx_grant = 1'b0;
  logic        push_ready, push_done, tx_request, tx_busy, mil_TXout, mil_nTXout;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [17:0] model_q[$];

  typedef struct {
    logic [1:0]  t;
    logic [15:0] d;
    logic        done;
    logic        rdy;
  } vec_t;
  vec_t tbl[6];

  mil_transmitter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .nRst(nRst), .ioStrobe(ioStrobe),
    .push_request(push_request), .push_type(push_type), .push_data(push_data),
    .push_ready(push_ready), .push_done(push_done),
    .tx_grant(tx_grant), .tx_request(tx_request), .tx_busy(tx_busy),
    .mil_TXout(mil_TXout), .mil_nTXout(mil_nTXout)
  );

  always #5 clk = ~clk;

  // Half-bit strobe: one clock in every four.
  initial begin : strobe_gen
    int sdiv;
    sdiv = 0;
    forever begin
      @(posedge clk);
      #1;
      sdiv++;
      ioStrobe = (sdiv % 4 == 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference half-bit k (0..39) of a word {type, data}.
  function automatic logic exp_hb(input logic [17:0] w, input int k);
    logic [15:0] d;
    logic p;
    int b;
    d = w[15:0];
    p = ($countones(d) % 2 == 0);
    if (k < 6) return (k < 3) == (w[17:16] == 2'b01);
    if (k < 38) begin
      b = (k - 6) / 2;
      return ((k - 6) % 2 == 0) ? d[15-b] : !d[15-b];
    end
    return (k == 38) ? p : !p;
  endfunction

  task automatic strobe_sample(output logic [2:0] s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ioStrobe && n < 50);
    if (!ioStrobe) begin
      total_cnt++;
      $display("FAIL strobe_wait: no strobe within %0d clocks", n);
    end
    @(posedge clk);
    #2;
    s = {mil_TXout, mil_nTXout, tx_busy};
  endtask

  task automatic push_word(input logic [1:0] t, input logic [15:0] d, output logic done);
    push_type = t;
    push_data = d;
    push_request = 1'b1;
    @(posedge clk);
    #2;
    push_request = 1'b0;
    done = push_done;
  endtask

  task automatic expect_word(input logic [17:0] w, input int from, input int to);
    logic [2:0] s;
    logic e;
    for (int k = from; k <= to; k++) begin
      strobe_sample(s);
      e = exp_hb(w, k);
      check($sformatf("halfbit%0d", k), 40'(s), 40'({e, !e, 1'b1}));
    end
  endtask

  task automatic expect_idle(input int n, input logic req);
    logic [2:0] s;
    for (int k = 0; k < n; k++) begin
      strobe_sample(s);
      check("idle_lines_req", 40'({s, tx_request}), 40'({3'b000, req}));
    end
  endtask

  task automatic expect_stream();
    logic [17:0] w;
    int i;
    i = 0;
    while (model_q.size() > 0) begin
      w = model_q.pop_front();
      if (i > 0 && GAP_HB > 0) expect_idle(GAP_HB, 1'b1);
      expect_word(w, 0, 39);
      i++;
    end
    expect_idle(10, 1'b0);
  endtask

  task automatic literal_word(input logic [1:0] t, input logic [39:0] lit, input string nm);
    logic [39:0] cap, ncap;
    logic [2:0] s;
    logic busy_all, done;
    cap = '0;
    ncap = '0;
    busy_all = 1'b1;
    tx_grant = 1'b1;
    push_word(t, 16'h02A1, done);
    check({nm, "_done"}, 40'(done), 40'(1'b1));
    for (int k = 0; k < 40; k++) begin
      strobe_sample(s);
      cap = {cap[38:0], s[2]};
      ncap = {ncap[38:0], s[1]};
      busy_all = busy_all & s[0];
    end
    check({nm, "_tx"}, cap, lit);
    check({nm, "_ntx"}, ncap, ~lit);
    check({nm, "_busy"}, 40'(busy_all), 40'(1'b1));
    expect_idle(10, 1'b0);
    tx_grant = 1'b0;
  endtask

  initial begin : main
    logic done;
    logic [17:0] w1, w2;
    int n;
    logic [1:0] t;
    logic [15:0] d;

    tbl[0] = '{2'b01, 16'h02A1, 1'b1, 1'b1};
    tbl[1] = '{2'b10, 16'h02A1, 1'b1, 1'b1};
    tbl[2] = '{2'b11, 16'hFFFF, 1'b1, 1'b1};
    tbl[3] = '{2'b01, 16'h1234, 1'b1, 1'b1};
    tbl[4] = '{2'b10, 16'h8000, 1'b1, 1'b0};
    tbl[5] = '{2'b01, 16'h5555, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", 40'({push_done, tx_request, tx_busy, mil_TXout, mil_nTXout}), 40'(5'b00000));
    nRst = 1'b1;
    @(posedge clk);
    #2;
    check("reset_release", 40'({push_ready, push_done, tx_request, tx_busy}), 40'(4'b1000));

    // Fixed WSERV and WDATA words for 0x02A1
    literal_word(2'b01, LIT_S, "wserv");
    literal_word(2'b10, LIT_D, "wdata");

    // Table-driven pushes with no grant, then the queued words drain in order
    for (int i = 0; i < 6; i++) begin
      push_word(tbl[i].t, tbl[i].d, done);
      check($sformatf("tbl%0d_done", i), 40'(done), 40'(tbl[i].done));
      check($sformatf("tbl%0d_ready", i), 40'(push_ready), 40'(tbl[i].rdy));
      if (tbl[i].done && (tbl[i].t == 2'b01 || tbl[i].t == 2'b10))
        model_q.push_back({tbl[i].t, tbl[i].d});
      @(posedge clk);
      #2;
      check("done_pulse_end", 40'(push_done), 40'(1'b0));
    end
    check("queued_no_grant", 40'({tx_request, mil_TXout, mil_nTXout, tx_busy}), 40'(4'b1000));
    tx_grant = 1'b1;
    expect_stream();
    tx_grant = 1'b0;
    check("ready_after_drain", 40'(push_ready), 40'(1'b1));

    // Grant dropped mid-word with a second word queued
    w1 = {2'b01, 16'($urandom)};
    w2 = {2'b10, 16'($urandom)};
    push_word(w1[17:16], w1[15:0], done);
    push_word(w2[17:16], w2[15:0], done);
    tx_grant = 1'b1;
    expect_word(w1, 0, 9);
    tx_grant = 1'b0;
    expect_word(w1, 10, 39);
    expect_idle(12, 1'b1);
    tx_grant = 1'b1;
    expect_word(w2, 0, 39);
    expect_idle(10, 1'b0);
    tx_grant = 1'b0;

    // Reset mid-word aborts the word and loses the queue
    w1 = {2'b10, 16'($urandom)};
    push_word(w1[17:16], w1[15:0], done);
    push_word(2'b01, 16'($urandom), done);
    tx_grant = 1'b1;
    expect_word(w1, 0, 19);
    #3;
    nRst = 1'b0;
    #1;
    check("reset_mid_immediate", 40'({mil_TXout, mil_nTXout, tx_busy, tx_request}), 40'(4'b0000));
    repeat (2) @(posedge clk);
    #2;
    nRst = 1'b1;
    @(posedge clk);
    #2;
    check("reset_mid_release", 40'({push_ready, tx_request, tx_busy}), 40'(3'b100));
    expect_idle(10, 1'b0);
    tx_grant = 1'b0;

    // Random batches against the reference model
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        t = 2'($urandom_range(0, 3));
        d = 16'($urandom);
        push_word(t, d, done);
        check("rand_done", 40'(done), 40'(1'b1));
        if (t == 2'b01 || t == 2'b10) model_q.push_back({t, d});
      end
      check("rand_request", 40'({tx_request, tx_busy}), 40'({model_q.size() != 0, 1'b0}));
      tx_grant = 1'b1;
      expect_stream();
      tx_grant = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mil_transmitter.md
MIL_TRANSMITTER -- requirements
Module: mil_transmitter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of queued words (power of two, >=2).
REQ-002 One clock; reset is asynchronous and active-low: clk  input  1  system clock, all logic rising-edge.
REQ-003 nRst  input  1  asynchronous active-low reset.
REQ-004 ioStrobe  input  1  one-clk pulse per Manchester half-bit period (e.g. 2 MHz for 1 Mbit/s); clk-domain signal.
REQ-005 push_request  input  1  producer offers a word (valid).
REQ-006 push_type  input  2  word type: 2'b01 WSERV (command/status sync), 2'b10 WDATA (data sync).
REQ-007 push_data  input  16  word payload, MSB transmitted first.
REQ-008 push_ready  output  1  FIFO can accept a word.
REQ-009 push_done  output  1  one-clk pulse the cycle after a word is accepted.
REQ-010 tx_grant  input  1  bus arbiter permits transmission.
REQ-011 tx_request  output  1  transmitter wants the bus.
REQ-012 tx_busy  output  1  a word is being driven on the line.
REQ-013 mil_TXout  output  1  positive line drive.
REQ-014 mil_nTXout  output  1  negative line drive.

Function
REQ-015 Accept when push_request && push_ready on a clk edge; push_type other than 01/10 is acknowledged (push_done) but discarded.
REQ-016 push_ready = FIFO not full; simultaneous accept and pop in one cycle permitted when full.
REQ-017 tx_request = FIFO non-empty or tx_busy, combinational from registered state.
REQ-018 FSM states IDLE, SYNC, DATA, PARITY (plus GAP, see Configuration); IDLE->SYNC on an ioStrobe with tx_grant=1 and FIFO non-empty, word popped that cycle.
REQ-019 Each line level holds exactly one ioStrobe period; level changes only on clk edges where ioStrobe=1.
REQ-020 SYNC: 6 half-bits; WSERV = 3 high then 3 low, WDATA = 3 low then 3 high.
REQ-021 DATA: 16 bits MSB first, 2 half-bits each; bit 1 = high then low, bit 0 = low then high.
REQ-022 PARITY: one bit, odd parity over the 16 data bits, encoded as REQ-021.
REQ-023 Word = 40 half-bits; then next word starts immediately if FIFO non-empty and tx_grant=1, else IDLE.
REQ-024 During a word mil_TXout=level, mil_nTXout=!level; in IDLE/GAP both 0.
REQ-025 tx_busy high from first SYNC half-bit to end of last PARITY half-bit.
REQ-026 tx_grant deasserted mid-word: word completes, no further word started until grant returns.

Reset
REQ-027 nRst low: FIFO emptied, FSM IDLE, push_ready=1 (after release), push_done=0, tx_request=0, tx_busy=0, mil_TXout=0, mil_nTXout=0, effective immediately regardless of clk.
REQ-028 Reset mid-word aborts the word; lines return to 0 at once; queued words lost.

Configuration
REQ-029 Macro MIL_TX_GAP_EN defined: after each word FSM enters GAP for 8 half-bits (4 us), lines 0, tx_busy 0, tx_request held 1 if FIFO non-empty, then next word; undefined: words back-to-back per REQ-023.

Verification
REQ-030 WSERV 0x02A1, grant=1 -> half-bits HHHLLL, then 0000 0010 1010 0001 Manchester-coded, parity bit 1 (HL); 40 strobes total, nTX always complement.
REQ-031 WDATA 0x02A1 -> sync LLLHHH, identical data and parity half-bits.
REQ-032 Push WSERV 0x02A1 then WDATA 0x02A1 with grant=0 -> two push_done pulses, tx_request=1, lines 0; raise grant -> both words transmitted in order, back-to-back (gap 8 half-bits with MIL_TX_GAP_EN).
REQ-033 Push FIFO_DEPTH+1 words with grant=0 -> push_ready=0 after 4th, 5th not accepted, no push_done for it.
REQ-034 Assert nRst at half-bit 20 of a word -> lines, tx_busy, tx_request 0 immediately, push_ready 1 after release.
REQ-035 Drop tx_grant at half-bit 10 with second word queued -> first word completes 40 half-bits, second not started, tx_request stays 1.
